// File: rtl/uart_rx_autobaud_ctrl_pkg.sv
// Shared definitions for the autobaud controller: FSM encoding, reset baud
// divisor and the sync/settle/break multipliers reused by the receiver bench.
package uart_rx_autobaud_ctrl_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    MEAS   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Receiver divisor driven until the first successful lock.
  localparam int DEF_O = 8;

  // A 0x55 character shows five falling edges spanning eight bit periods.
  localparam int SYNC_EDGES = 5;

  // Idle-high time required before locking, and low time taken as a break,
  // both in multiples of the measured bit period.
  localparam int SETTLE_FACTOR = 2;
  localparam int BREAK_FACTOR  = 16;

endpackage

// File: rtl/uart_byte_hold.sv
// Drains bytes from the receiver via its dr/dr_rst handshake into a
// one-entry valid/ready stage; bytes are forwarded only while enabled.
module uart_byte_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  input  logic       clr_ovr,
  input  logic [7:0] rx_out,
  input  logic       rx_dr,
  input  logic       ready,
  output logic       rx_dr_rst,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun
);

  logic dr_rst_d1;
  logic consider;
  logic take;
  logic space;

  // The flag is ignored while the clear pulse is out and for one cycle after,
  // so the receiver has time to drop it.
  assign consider = rx_dr & ~rx_dr_rst & ~dr_rst_d1;
  assign take     = consider & en & ~flush;
  assign space    = ~valid | ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_dr_rst <= 1'b0;
      dr_rst_d1 <= 1'b0;
      data      <= 8'h00;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_dr_rst <= consider;
      dr_rst_d1 <= rx_dr_rst;

      if (take && space) begin
        data <= rx_out;
      end

      if (flush || !en) begin
        valid <= 1'b0;
      end else if (take && space) begin
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end

      if (clr_ovr) begin
        overrun <= 1'b0;
      end else if (take && !space) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_autobaud_ctrl.sv
// Autobaud controller: measures a 0x55 sync character on the raw RX line,
// programs the receiver divisor and drains received bytes while locked.
module uart_rx_autobaud_ctrl
  import uart_rx_autobaud_ctrl_pkg::*;
#(
  parameter int OW    = 4,
  parameter int O_DEF = DEF_O,
  parameter int CW    = OW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          relock,
  output logic [OW-1:0] rx_o,
  input  logic [7:0]    rx_out,
  input  logic          rx_dr,
  output logic          rx_dr_rst,
  output logic [7:0]    data,
  output logic          valid,
  input  logic          ready,
  output logic          locked,
  output logic          overrun
);

  localparam int PMAX = (2 ** OW) - 1;

  logic rx_s1, rx_s2, rx_d;
  logic fall;

  state_t state, state_next;

  // One counter serves as the sync-span measurement in MEAS and as the
  // high/low run length in SETTLE and LOCKED.
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [2:0]    edge_cnt, edge_next;
  logic          load_o;

  logic [CW:0]   c_rnd;
  logic [CW-3:0] period;
  logic          period_ok;
  logic [CW-1:0] settle_len, break_len;
  logic          flush;

  assign fall    = rx_d & ~rx_s2;
  assign cnt_inc = cnt + CW'(1);

  // Bit period rounded to nearest: (C + 4) >> 3 over eight bit times.
  assign c_rnd     = {1'b0, cnt} + (CW + 1)'(4);
  assign period    = c_rnd[CW:3];
  assign period_ok = (period >= (CW - 2)'(2)) && (period <= (CW - 2)'(PMAX));

  assign settle_len = CW'(rx_o) * CW'(SETTLE_FACTOR);
  assign break_len  = CW'(rx_o) * CW'(BREAK_FACTOR);

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    edge_next  = edge_cnt;
    load_o     = 1'b0;

    case (state)
      HUNT: begin
        cnt_next  = '0;
        edge_next = '0;
        if (fall) begin
          cnt_next   = CW'(1);
          edge_next  = 3'd1;
          state_next = MEAS;
        end
      end

      MEAS: begin
        cnt_next = cnt_inc;
        if (fall) begin
          edge_next = edge_cnt + 3'd1;
        end
        if (fall && (edge_cnt == 3'(SYNC_EDGES - 1))) begin
          cnt_next  = '0;
          edge_next = '0;
          if (period_ok) begin
            load_o     = 1'b1;
            state_next = SETTLE;
          end else begin
            state_next = HUNT;
          end
        end else if (cnt == '1) begin
          cnt_next   = '0;
          edge_next  = '0;
          state_next = HUNT;
        end
      end

      SETTLE: begin
        if (rx_s2) begin
          cnt_next = cnt_inc;
          if (cnt_inc == settle_len) begin
            cnt_next   = '0;
            state_next = LOCKED;
          end
        end else begin
          cnt_next = '0;
        end
      end

      LOCKED: begin
        if (!rx_s2) begin
          cnt_next = cnt_inc;
          if (cnt_inc == break_len) begin
            cnt_next   = '0;
            state_next = HUNT;
          end
        end else begin
          cnt_next = '0;
        end
      end

      default: state_next = HUNT;
    endcase

    // Relock overrides a lock completion or break seen in the same cycle.
    if (relock) begin
      state_next = HUNT;
      cnt_next   = '0;
      edge_next  = '0;
      load_o     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      state    <= HUNT;
      cnt      <= '0;
      edge_cnt <= '0;
      rx_o     <= OW'(O_DEF);
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      state    <= state_next;
      cnt      <= cnt_next;
      edge_cnt <= edge_next;
      if (load_o) begin
        rx_o <= period[OW-1:0];
      end
    end
  end

  assign locked = (state == LOCKED);

  // Drop the held byte in the same cycle the lock is lost.
  assign flush = locked && (state_next != LOCKED);

  uart_byte_hold u_hold (
    .clk       (clk),
    .rst       (rst),
    .en        (locked),
    .flush     (flush),
    .clr_ovr   (relock),
    .rx_out    (rx_out),
    .rx_dr     (rx_dr),
    .ready     (ready),
    .rx_dr_rst (rx_dr_rst),
    .data      (data),
    .valid     (valid),
    .overrun   (overrun)
  );

endmodule
